regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Multi-port integer register file with a per-register scoreboard (pending bits) and optional write-to-read bypass.
- Successor to the plain multi-port regfile. Serves the dual-issue pipeline, where issue marks destination registers pending and writeback clears them.
- Decode and issue use rvalid/busy to stall on RAW hazards without a separate scoreboard block.

Parameters:
REG_NUM, 32, number of architectural registers
DATA_WIDTH, 32, register width in bits
WRITE_PORTS, 2, writeback ports
READ_PORTS, 4, read ports
ISSUE_PORTS, 2, destination-mark ports from issue stage
ZERO_KEEP, 1, regs[0:ZERO_KEEP-1] hardwired to 0, never pending

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
we  in  WRITE_PORTS  write enable per port
waddr  in  WRITE_PORTS x $clog2(REG_NUM)  write address
wdata  in  WRITE_PORTS x DATA_WIDTH  write data
raddr  in  READ_PORTS x $clog2(REG_NUM)  read address
rdata  out  READ_PORTS x DATA_WIDTH  read data, combinational
rvalid  out  READ_PORTS  1 = rdata is final (register not pending)
issue_valid  in  ISSUE_PORTS  mark destination pending
issue_addr  in  ISSUE_PORTS x $clog2(REG_NUM)  destination to mark
flush  in  1  clear all pending bits (pipeline squash)
busy  out  REG_NUM  current pending vector (registered)

Behaviour:
- Reset: rst_n low at posedge clears all regs and pending bits to 0 on the next cycle. busy=0 and every rvalid=1 after reset. Reset overrides write, issue and flush in the same cycle.
- Write:
  - Register i>=ZERO_KEEP takes wdata[j] at the next posedge when we[j] && waddr[j]==i.
  - Several ports writing the same register: highest port index wins.
  - Writes to i<ZERO_KEEP are ignored.
- Read: rdata[k]=regs[raddr[k]] combinationally; 0 if raddr[k]<ZERO_KEEP.
- Pending update per register i>=ZERO_KEEP, in priority order, evaluated at posedge:
  - Priority 1: flush=1 -> pending=0. Issues in that cycle are dropped; writes still commit.
  - Priority 2: else any issue_valid[m] with issue_addr[m]==i -> pending=1. Issue beats a same-cycle write to i, because a new producer was issued.
  - Priority 3: else any we[j] with waddr[j]==i -> pending=0.
  - Priority 4: else hold.
- Pending for i<ZERO_KEEP is constant 0, and issue to those registers is ignored.
- Duplicate issue to an already-pending register: stays 1. No counting; only one outstanding producer per register is tracked.
- rvalid[k]=!pending[raddr[k]] in the base build. Adjusted by bypass when that feature is compiled in.
- busy is the pending register array directly; it updates one cycle after issue/write/flush.
- Latency: write visible on rdata the cycle after we. Pending visible the cycle after issue_valid.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose raddr matches an active write port (we[j] && waddr[j]==raddr && raddr>=ZERO_KEEP) returns that wdata in the same cycle; highest matching port wins.
  - rvalid=1 for that read even if the register is pending.
  - Bypass is independent of same-cycle issue and flush.
- Undefined:
  - No forwarding; rdata shows the old value until the next cycle.
  - rvalid follows pending only.

Test Plan:
1. Reset: hold rst_n=0 one cycle with we=2'b11 to r5 -> regs all 0, busy=0, read r5=0 with rvalid=1.
2. Port conflict: we=2'b11, waddr={r3,r3}, wdata={0xBBBB,0xAAAA} -> next cycle r3=0xBBBB (port 1 wins). Write 0x1234 to r0 -> r0 still reads 0.
3. Scoreboard: issue r7 at cycle 0 -> busy[7]=1 at cycle 1 and rvalid=0 reading r7. Write r7=0x55 at cycle 2 -> at cycle 3 busy[7]=0, rdata=0x55, rvalid=1.
4. Simultaneous: r9 pending; same cycle issue r9 and write r9=0x77 -> next cycle r9=0x77 and busy[9]=1. Then flush together with issue r10 -> busy all 0, r10 not pending.
5. Bypass (REGFILE_BYPASS_EN): r4 pending; in the write cycle of r4=0xDEAD, read r4 -> rdata=0xDEAD, rvalid=1 that same cycle. Without the macro -> old value, rvalid=0.
6. Random mix on 4 read / 2 write / 2 issue ports for 10k cycles -> rdata, rvalid and busy match the reference model every cycle.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle for the scoreboarded register file.
//   master modport (issue/writeback/decode side):
//     drives  we, waddr, wdata, raddr, issue_valid, issue_addr, flush
//     samples rdata, rvalid, busy
//   slave modport (register file): the mirror image.
// The parameters must match the ones used on the regfile_sb instance.
interface regfile_sb_if #(
  parameter int REG_NUM     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4,
  parameter int ISSUE_PORTS = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic [WRITE_PORTS-1:0]                 we;
  logic [WRITE_PORTS-1:0][AW-1:0]         waddr;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata;
  logic [READ_PORTS-1:0][AW-1:0]          raddr;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata;
  logic [READ_PORTS-1:0]                  rvalid;
  logic [ISSUE_PORTS-1:0]                 issue_valid;
  logic [ISSUE_PORTS-1:0][AW-1:0]         issue_addr;
  logic                                   flush;
  logic [REG_NUM-1:0]                     busy;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_addr, flush,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_addr, flush,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register pending
// scoreboard, used by decode/issue to stall on RAW hazards.
//
// Ports:
//   clk   - clock, all state changes on posedge
//   rst_n - synchronous active-low reset; clears registers and pending bits
//   bus   - regfile_sb_if.slave:
//             we/waddr/wdata          writeback ports (highest index wins)
//             raddr -> rdata/rvalid   combinational read ports
//             issue_valid/issue_addr  mark destination registers pending
//             flush                   clear every pending bit
//             busy                    registered pending vector
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a read matching an active write port returns that port's
//               wdata in the same cycle with rvalid=1.
//   undefined - no forwarding; rvalid follows the pending bit only.
//
// Registers below ZERO_KEEP read as zero, ignore writes and never go pending.
module regfile_sb #(
  parameter int REG_NUM     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4,
  parameter int ISSUE_PORTS = 2,
  parameter int ZERO_KEEP   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0]                  regs [REG_NUM];
  logic [REG_NUM-1:0]                     pending;
  logic [REG_NUM-1:0]                     pending_nxt;
  logic [REG_NUM-1:0]                     issue_hit;
  logic [REG_NUM-1:0]                     write_hit;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_c;
  logic [READ_PORTS-1:0]                  rvalid_c;

  // Decode which registers are targeted this cycle by issue and writeback.
  always_comb begin
    issue_hit = '0;
    write_hit = '0;
    for (int m = 0; m < ISSUE_PORTS; m++)
      if (bus.issue_valid[m]) issue_hit[bus.issue_addr[m]] = 1'b1;
    for (int j = 0; j < WRITE_PORTS; j++)
      if (bus.we[j]) write_hit[bus.waddr[j]] = 1'b1;
  end

  // Scoreboard priority: flush, then a new producer (issue), then writeback.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < REG_NUM; i++) begin
      if (i < ZERO_KEEP)      pending_nxt[i] = 1'b0;
      else if (bus.flush)     pending_nxt[i] = 1'b0;
      else if (issue_hit[i])  pending_nxt[i] = 1'b1;
      else if (write_hit[i])  pending_nxt[i] = 1'b0;
      else                    pending_nxt[i] = pending[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      // Ascending port scan: the last assignment (highest port) wins.
      for (int i = ZERO_KEEP; i < REG_NUM; i++)
        for (int j = 0; j < WRITE_PORTS; j++)
          if (bus.we[j] && bus.waddr[j] == AW'(i)) regs[i] <= bus.wdata[j];
      pending <= pending_nxt;
    end
  end

  always_comb begin
    rdata_c  = '0;
    rvalid_c = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      if (int'(bus.raddr[k]) < ZERO_KEEP) rdata_c[k] = '0;
      else                                rdata_c[k] = regs[bus.raddr[k]];
      rvalid_c[k] = !pending[bus.raddr[k]];
`ifdef REGFILE_BYPASS_EN
      // Forward in-flight writeback data; highest matching port wins.
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (bus.we[j] && bus.waddr[j] == bus.raddr[k] &&
            int'(bus.raddr[k]) >= ZERO_KEEP) begin
          rdata_c[k]  = bus.wdata[j];
          rvalid_c[k] = 1'b1;
        end
      end
`endif
    end
  end

  assign bus.rdata  = rdata_c;
  assign bus.rvalid = rvalid_c;
  assign bus.busy   = pending;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int REG_NUM = 32;
  localparam int DW      = 32;
  localparam int WP      = 2;
  localparam int RP      = 4;
  localparam int IP      = 2;
  localparam int ZK      = 1;
  localparam int AW      = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_sb_if #(
    .REG_NUM(REG_NUM), .DATA_WIDTH(DW), .WRITE_PORTS(WP),
    .READ_PORTS(RP), .ISSUE_PORTS(IP)
  ) bus ();

  regfile_sb #(
    .REG_NUM(REG_NUM), .DATA_WIDTH(DW), .WRITE_PORTS(WP),
    .READ_PORTS(RP), .ISSUE_PORTS(IP), .ZERO_KEEP(ZK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a posedge; outputs sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we          = '0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.raddr       = '0;
    bus.issue_valid = '0;
    bus.issue_addr  = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.we = 2'b11;
    bus.waddr[0] = AW'(5); bus.wdata[0] = 32'h1111_1111;
    bus.waddr[1] = AW'(5); bus.wdata[1] = 32'h2222_2222;
    bus.issue_valid = 2'b01; bus.issue_addr[0] = AW'(6);
    tick();
    rst_n = 1'b1;
    idle();
    bus.raddr[0] = AW'(5);
    bus.raddr[1] = AW'(6);
    #2;
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++; $display("FAIL reset_busy got %h want %h", bus.busy, 32'h0);
    end
    checks++;
    if (bus.rdata[0] !== 32'h0) begin
      errors++; $display("FAIL reset_r5_data got %h want %h", bus.rdata[0], 32'h0);
    end
    checks++;
    if (bus.rvalid !== 4'hF) begin
      errors++; $display("FAIL reset_rvalid got %b want %b", bus.rvalid, 4'hF);
    end
  endtask

  task automatic test_port_conflict();
    idle();
    bus.we = 2'b11;
    bus.waddr[0] = AW'(3); bus.wdata[0] = 32'h0000_AAAA;
    bus.waddr[1] = AW'(3); bus.wdata[1] = 32'h0000_BBBB;
    tick();
    idle();
    bus.raddr[0] = AW'(3);
    #2;
    checks++;
    if (bus.rdata[0] !== 32'h0000_BBBB) begin
      errors++; $display("FAIL conflict_r3 got %h want %h", bus.rdata[0], 32'h0000_BBBB);
    end
    tick();
    bus.we = 2'b01;
    bus.waddr[0] = AW'(0); bus.wdata[0] = 32'h0000_1234;
    bus.issue_valid = 2'b10; bus.issue_addr[1] = AW'(0);
    tick();
    idle();
    bus.raddr[2] = AW'(0);
    #2;
    checks++;
    if (bus.rdata[2] !== 32'h0) begin
      errors++; $display("FAIL zero_reg_data got %h want %h", bus.rdata[2], 32'h0);
    end
    checks++;
    if (bus.rvalid[2] !== 1'b1 || bus.busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_reg_pending got rvalid=%b busy0=%b want 1/0",
                         bus.rvalid[2], bus.busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 2'b01; bus.issue_addr[0] = AW'(7);
    tick();
    idle();
    bus.raddr[1] = AW'(7);
    #2;
    checks++;
    if (bus.busy !== 32'h0000_0080) begin
      errors++; $display("FAIL sb_busy_set got %h want %h", bus.busy, 32'h0000_0080);
    end
    checks++;
    if (bus.rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL sb_rvalid_pending got %b want 0", bus.rvalid[1]);
    end
    tick();
    bus.we = 2'b10;
    bus.waddr[1] = AW'(7); bus.wdata[1] = 32'h55;
    tick();
    idle();
    bus.raddr[1] = AW'(7);
    #2;
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++; $display("FAIL sb_busy_clear got %h want %h", bus.busy, 32'h0);
    end
    checks++;
    if (bus.rdata[1] !== 32'h55 || bus.rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL sb_writeback got %h/%b want 00000055/1",
                         bus.rdata[1], bus.rvalid[1]);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    bus.issue_valid = 2'b01; bus.issue_addr[0] = AW'(9);
    tick();
    idle();
    bus.issue_valid = 2'b10; bus.issue_addr[1] = AW'(9);
    bus.we = 2'b01; bus.waddr[0] = AW'(9); bus.wdata[0] = 32'h77;
    tick();
    idle();
    bus.raddr[3] = AW'(9);
    #2;
    checks++;
    if (bus.busy !== 32'h0000_0200) begin
      errors++; $display("FAIL issue_beats_write_busy got %h want %h", bus.busy, 32'h0000_0200);
    end
    checks++;
    if (bus.rdata[3] !== 32'h77 || bus.rvalid[3] !== 1'b0) begin
      errors++; $display("FAIL issue_beats_write_read got %h/%b want 00000077/0",
                         bus.rdata[3], bus.rvalid[3]);
    end
    tick();
    bus.flush = 1'b1;
    bus.issue_valid = 2'b01; bus.issue_addr[0] = AW'(10);
    bus.we = 2'b10; bus.waddr[1] = AW'(11); bus.wdata[1] = 32'h11;
    tick();
    idle();
    bus.raddr[0] = AW'(10);
    bus.raddr[1] = AW'(11);
    #2;
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++; $display("FAIL flush_busy got %h want %h", bus.busy, 32'h0);
    end
    checks++;
    if (bus.rvalid[0] !== 1'b1) begin
      errors++; $display("FAIL flush_drops_issue got %b want 1", bus.rvalid[0]);
    end
    checks++;
    if (bus.rdata[1] !== 32'h11) begin
      errors++; $display("FAIL flush_write_commits got %h want %h", bus.rdata[1], 32'h11);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.issue_valid = 2'b01; bus.issue_addr[0] = AW'(4);
    tick();
    idle();
    bus.we = 2'b01; bus.waddr[0] = AW'(4); bus.wdata[0] = 32'h0000_DEAD;
    bus.raddr[1] = AW'(4);
    #2;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (bus.rdata[1] !== 32'h0000_DEAD || bus.rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL bypass_same_cycle got %h/%b want 0000dead/1",
                         bus.rdata[1], bus.rvalid[1]);
    end
`else
    checks++;
    if (bus.rdata[1] !== 32'h0 || bus.rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL no_bypass_same_cycle got %h/%b want 00000000/0",
                         bus.rdata[1], bus.rvalid[1]);
    end
`endif
    tick();
    idle();
    bus.raddr[1] = AW'(4);
    #2;
    checks++;
    if (bus.rdata[1] !== 32'h0000_DEAD || bus.rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL bypass_after_commit got %h/%b want 0000dead/1",
                         bus.rdata[1], bus.rvalid[1]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0]      m_regs [REG_NUM];
    logic [REG_NUM-1:0] m_pend;
    logic [DW-1:0]      exp_d;
    logic               exp_v;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;
    m_pend = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < WP; j++) begin
        bus.we[j]    = ($urandom_range(0, 2) == 0);
        bus.waddr[j] = AW'($urandom_range(0, REG_NUM - 1));
        bus.wdata[j] = $urandom;
      end
      for (int m = 0; m < IP; m++) begin
        bus.issue_valid[m] = ($urandom_range(0, 2) == 0);
        bus.issue_addr[m]  = AW'($urandom_range(0, REG_NUM - 1));
      end
      for (int k = 0; k < RP; k++) bus.raddr[k] = AW'($urandom_range(0, REG_NUM - 1));
      bus.flush = ($urandom_range(0, 31) == 0);
      #2;
      for (int k = 0; k < RP; k++) begin
        exp_d = (int'(bus.raddr[k]) < ZK) ? '0 : m_regs[bus.raddr[k]];
        exp_v = !m_pend[bus.raddr[k]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < WP; j++)
          if (bus.we[j] && bus.waddr[j] == bus.raddr[k] && int'(bus.raddr[k]) >= ZK) begin
            exp_d = bus.wdata[j];
            exp_v = 1'b1;
          end
`endif
        checks++;
        if (bus.rdata[k] !== exp_d) begin
          errors++; $display("FAIL rand_rdata c=%0d k=%0d got %h want %h", c, k, bus.rdata[k], exp_d);
        end
        checks++;
        if (bus.rvalid[k] !== exp_v) begin
          errors++; $display("FAIL rand_rvalid c=%0d k=%0d got %b want %b", c, k, bus.rvalid[k], exp_v);
        end
      end
      checks++;
      if (bus.busy !== m_pend) begin
        errors++; $display("FAIL rand_busy c=%0d got %h want %h", c, bus.busy, m_pend);
      end
      // Reference update: writes first, then issue overrides, flush overrides all.
      for (int j = 0; j < WP; j++)
        if (bus.we[j] && int'(bus.waddr[j]) >= ZK) begin
          m_regs[bus.waddr[j]] = bus.wdata[j];
          m_pend[bus.waddr[j]] = 1'b0;
        end
      for (int m = 0; m < IP; m++)
        if (bus.issue_valid[m] && int'(bus.issue_addr[m]) >= ZK) m_pend[bus.issue_addr[m]] = 1'b1;
      if (bus.flush) m_pend = '0;
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    tick();
    test_reset();
    tick();
    test_port_conflict();
    tick();
    test_scoreboard();
    tick();
    test_simultaneous();
    tick();
    test_bypass();
    tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
